// File: rtl/sram_access_arbiter_if.sv
// Bundle of requester handshakes and SRAM-side strobes/data for the SRAM access arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/SRAM side.
interface sram_access_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              Cpu_Req;
  logic              Cpu_RW;
  logic [ADDR_W-1:0] Cpu_Addr;
  logic [DATA_W-1:0] Cpu_WData;
  logic [DATA_W-1:0] Cpu_RData;
  logic              Cpu_Ack;
  logic              Vid_Req;
  logic [ADDR_W-1:0] Vid_Addr;
  logic [DATA_W-1:0] Vid_RData;
  logic              Vid_Ack;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Data_ToSRAM;
  logic [DATA_W-1:0] Data_FromSRAM;
  logic              Mem_CE;
  logic              Mem_OE;
  logic              Mem_WE;
  logic              Mem_LB;
  logic              Mem_UB;
  logic              Busy;

  modport slave (
    input  Cpu_Req, Cpu_RW, Cpu_Addr, Cpu_WData,
    input  Vid_Req, Vid_Addr,
    input  Data_FromSRAM,
    output Cpu_RData, Cpu_Ack, Vid_RData, Vid_Ack,
    output Address, Data_ToSRAM,
    output Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB,
    output Busy
  );

  modport master (
    output Cpu_Req, Cpu_RW, Cpu_Addr, Cpu_WData,
    output Vid_Req, Vid_Addr,
    output Data_FromSRAM,
    input  Cpu_RData, Cpu_Ack, Vid_RData, Vid_Ack,
    input  Address, Data_ToSRAM,
    input  Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB,
    input  Busy
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one 16-bit SRAM between the CPU (read/write) and video (read-only),
// sequencing each access as SETUP -> ACCESS (ACCESS_CYCLES) -> DONE with active-high strobes.
module sram_access_arbiter #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic Clk,
  input  logic Reset,
  sram_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    GNT_CPU,
    GNT_VID
  } grant_t;

  // Counter is loaded in SETUP and counts the ACCESS cycles down to zero.
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  grant_t            grant;
  grant_t            last_grant;
  grant_t            win_grant;
  logic              rw;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] vid_rdata_q;
  logic              any_req;
  logic              cpu_wins;
  logic              access_last;

  always_comb begin
    any_req     = bus.Cpu_Req || bus.Vid_Req;
    // On a tie the requester that was not granted last time wins.
    cpu_wins    = bus.Cpu_Req && (!bus.Vid_Req || (last_grant == GNT_VID));
    win_grant   = cpu_wins ? GNT_CPU : GNT_VID;
    access_last = (state == ACCESS) && (cnt == 4'd0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (access_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      grant       <= GNT_VID;
      last_grant  <= GNT_VID;
      rw          <= 1'b0;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= win_grant;
            last_grant <= win_grant;
            addr_q     <= cpu_wins ? bus.Cpu_Addr : bus.Vid_Addr;
            rw         <= cpu_wins && bus.Cpu_RW;
            wdata_q    <= (cpu_wins && bus.Cpu_RW) ? bus.Cpu_WData : '0;
          end
        end
        SETUP: cnt <= CNT_LOAD;
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!rw) begin
            if (grant == GNT_CPU) begin
              cpu_rdata_q <= bus.Data_FromSRAM;
            end else begin
              vid_rdata_q <= bus.Data_FromSRAM;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.Mem_CE      = 1'b0;
    bus.Mem_OE      = 1'b0;
    bus.Mem_WE      = 1'b0;
    bus.Mem_LB      = 1'b0;
    bus.Mem_UB      = 1'b0;
    bus.Cpu_Ack     = 1'b0;
    bus.Vid_Ack     = 1'b0;
    bus.Busy        = (state != IDLE);
    bus.Address     = addr_q;
    bus.Data_ToSRAM = wdata_q;
    bus.Cpu_RData   = cpu_rdata_q;
    bus.Vid_RData   = vid_rdata_q;
    case (state)
      SETUP: begin
        bus.Mem_CE = 1'b1;
        bus.Mem_LB = 1'b1;
        bus.Mem_UB = 1'b1;
        bus.Mem_OE = !rw;
      end
      ACCESS: begin
        bus.Mem_CE = 1'b1;
        bus.Mem_LB = 1'b1;
        bus.Mem_UB = 1'b1;
        bus.Mem_OE = !rw;
        bus.Mem_WE = rw;
      end
      DONE: begin
        bus.Cpu_Ack = (grant == GNT_CPU);
        bus.Vid_Ack = (grant == GNT_VID);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: directed timing scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-phase model and a reference memory.
module tb_sram_access_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned AC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  function automatic logic [15:0] seed_word(input int unsigned a);
    return 16'((a * 32'h9E37) ^ 32'h5A5A);
  endfunction

  // SRAM device driven purely by the DUT pins.
  logic [15:0] sram [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = seed_word(i);
    forever begin
      @(posedge clk);
      if (bus.Mem_CE && bus.Mem_WE) sram[bus.Address] = bus.Data_ToSRAM;
    end
  end
  assign bus.Data_FromSRAM = (bus.Mem_CE && bus.Mem_OE) ? sram[bus.Address] : 16'hDEAD;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: k counts cycles since the grant (0 = no transaction).
  logic [15:0] ref_mem [0:65535];
  int unsigned k = 0;
  logic        m_cpu = 1'b0;
  logic        m_rw = 1'b0;
  logic        last_vid = 1'b1;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] e_cpu_rd = '0;
  logic [15:0] e_vid_rd = '0;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = seed_word(i);
    forever begin
      @(posedge clk);
      cyc++;
      if (k == 2 && m_rw) ref_mem[m_addr] = m_wdata;
      if (k == 1 + AC && !m_rw) begin
        if (m_cpu) e_cpu_rd = ref_mem[m_addr];
        else       e_vid_rd = ref_mem[m_addr];
      end
      if (k == 2 + AC) begin
        k = 0;
      end else if (k != 0) begin
        k++;
      end else if (bus.Cpu_Req || bus.Vid_Req) begin
        m_cpu    = bus.Cpu_Req && (!bus.Vid_Req || last_vid);
        last_vid = !m_cpu;
        m_addr   = m_cpu ? bus.Cpu_Addr : bus.Vid_Addr;
        m_rw     = m_cpu && bus.Cpu_RW;
        m_wdata  = m_rw ? bus.Cpu_WData : 16'h0000;
        k        = 1;
      end
      if (rst) begin
        k        = 0;
        e_cpu_rd = '0;
        e_vid_rd = '0;
        m_addr   = '0;
        m_wdata  = '0;
        last_vid = 1'b1;
      end
    end
  end

  function automatic logic [15:0] dut_flags();
    return {8'h00, bus.Busy, bus.Mem_CE, bus.Mem_OE, bus.Mem_WE,
            bus.Mem_LB, bus.Mem_UB, bus.Cpu_Ack, bus.Vid_Ack};
  endfunction

  initial begin
    logic ce, we, ack;
    @(posedge clk);
    forever begin
      @(negedge clk);
      ce  = (k >= 1) && (k <= 1 + AC);
      we  = m_rw && (k >= 2) && (k <= 1 + AC);
      ack = (k == 2 + AC);
      check("flags", dut_flags(),
            {8'h00, k != 0, ce, ce && !m_rw, we, ce, ce, ack && m_cpu, ack && !m_cpu});
      check("address", bus.Address, m_addr);
      check("data_to_sram", bus.Data_ToSRAM, m_wdata);
      check("cpu_rdata", bus.Cpu_RData, e_cpu_rd);
      check("vid_rdata", bus.Vid_RData, e_vid_rd);
    end
  end

  task automatic observe(input int n, output logic [15:0] ce_v, output logic [15:0] we_v,
                         output logic [15:0] oe_v, output logic [15:0] ca_v,
                         output logic [15:0] va_v);
    ce_v = '0; we_v = '0; oe_v = '0; ca_v = '0; va_v = '0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      ce_v[i] = bus.Mem_CE;
      we_v[i] = bus.Mem_WE;
      oe_v[i] = bus.Mem_OE;
      ca_v[i] = bus.Cpu_Ack;
      va_v[i] = bus.Vid_Ack;
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic rand_cpu_fields();
    bus.Cpu_RW    = 1'($urandom_range(0, 1));
    bus.Cpu_Addr  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
    bus.Cpu_WData = 16'($urandom);
  endtask

  task automatic rand_vid_fields();
    bus.Vid_Addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
  endtask

  initial begin
    logic [15:0] ce_v, we_v, oe_v, ca_v, va_v;
    bit got;
    bus.Cpu_Req = 1'b1; bus.Cpu_RW = 1'b1; bus.Cpu_Addr = 16'h1234; bus.Cpu_WData = 16'h5555;
    bus.Vid_Req = 1'b1; bus.Vid_Addr = 16'h0042;

    // Reset held three cycles with both requests high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_flags", dut_flags(), 16'h0000);
      check("t1_addr", bus.Address, 16'h0000);
    end
    rst = 1'b0; bus.Cpu_Req = 1'b0; bus.Vid_Req = 1'b0;
    gap(2);

    // CPU write 0x3000 <- 0xCAFE
    bus.Cpu_Req = 1'b1; bus.Cpu_RW = 1'b1; bus.Cpu_Addr = 16'h3000; bus.Cpu_WData = 16'hCAFE;
    observe(4, ce_v, we_v, oe_v, ca_v, va_v);
    check("t2_ce", ce_v, 16'h000E);
    check("t2_we", we_v, 16'h000C);
    check("t2_ack", ca_v, 16'h0010);
    check("t2_addr", bus.Address, 16'h3000);
    check("t2_wdata", bus.Data_ToSRAM, 16'hCAFE);
    bus.Cpu_Req = 1'b0;
    gap(2);

    // CPU read back 0x3000
    bus.Cpu_Req = 1'b1; bus.Cpu_RW = 1'b0;
    observe(4, ce_v, we_v, oe_v, ca_v, va_v);
    check("t3_oe", oe_v, 16'h000E);
    check("t3_we", we_v, 16'h0000);
    check("t3_ack", ca_v, 16'h0010);
    check("t3_rdata", bus.Cpu_RData, 16'hCAFE);
    bus.Cpu_Req = 1'b0;

    // Fresh reset so the CPU wins the first tie.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.Cpu_Req = 1'b1; bus.Cpu_RW = 1'b0; bus.Cpu_Addr = 16'h0007; bus.Vid_Req = 1'b1;
    observe(14, ce_v, we_v, oe_v, ca_v, va_v);
    check("t4_cpu_ack", ca_v, 16'h4010);
    check("t4_vid_ack", va_v, 16'h0200);
    bus.Cpu_Req = 1'b0; bus.Vid_Req = 1'b0;
    gap(2);

    // Reset in the second ACCESS cycle of a write to 0x0010.
    bus.Cpu_Req = 1'b1; bus.Cpu_RW = 1'b1; bus.Cpu_Addr = 16'h0010; bus.Cpu_WData = 16'hBEEF;
    gap(3);
    check("t5_access2", dut_flags(), 16'h00DC);
    rst = 1'b1;
    @(negedge clk);
    check("t5_aborted", dut_flags(), 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("t5_setup", dut_flags(), 16'h00CC);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.Cpu_Ack;
    end
    check("t5_ack_seen", 16'(got), 16'h0001);
    bus.Cpu_Req = 1'b0;
    gap(2);

    // Video alone, CPU joins at cycle 2.
    bus.Vid_Req = 1'b1; bus.Vid_Addr = 16'h3000;
    bus.Cpu_RW = 1'b0; bus.Cpu_Addr = 16'h0010;
    observe(2, ce_v, we_v, oe_v, ca_v, va_v);
    bus.Cpu_Req = 1'b1;
    observe(12, ce_v, we_v, oe_v, ca_v, va_v);
    check("t6_vid_ack", va_v, 16'h1004);
    check("t6_cpu_ack", ca_v, 16'h0080);
    check("t6_cpu_rdata", bus.Cpu_RData, 16'hBEEF);
    bus.Cpu_Req = 1'b0; bus.Vid_Req = 1'b0;
    gap(2);

    // Random traffic with occasional early drops and reset pulses.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if (bus.Cpu_Req) begin
        if (bus.Cpu_Ack) begin
          if ($urandom_range(0, 2) == 0) rand_cpu_fields();
          else bus.Cpu_Req = 1'b0;
        end else if ($urandom_range(0, 49) == 0) begin
          bus.Cpu_Req = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        rand_cpu_fields();
        bus.Cpu_Req = 1'b1;
      end
      if (bus.Vid_Req) begin
        if (bus.Vid_Ack) begin
          if ($urandom_range(0, 2) == 0) rand_vid_fields();
          else bus.Vid_Req = 1'b0;
        end else if ($urandom_range(0, 49) == 0) begin
          bus.Vid_Req = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        rand_vid_fields();
        bus.Vid_Req = 1'b1;
      end
    end
    bus.Cpu_Req = 1'b0; bus.Vid_Req = 1'b0; rst = 1'b0;
    gap(10);
    check("final_idle", 16'(bus.Busy), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
